dp_arbiter: RTL and testbench

DP_ARBITER -- requirements
Module: dp_arbiter

---
 rtl/dp_arbiter_if.sv | 35 +++
 rtl/dp_arbiter.sv | 148 ++++++++++++++
 tb/tb_dp_arbiter.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dp_arbiter_if.sv
// Requester-side bus of the dynamic pointer arbiter: three request lanes in,
// one-hot grant plus completion/response out.
interface dp_arbiter_if #(
    parameter int DW = 20
);
    logic [2:0]      req;
    logic [5:0]      req_op;
    logic [3*DW-1:0] req_wdata;
    logic [2:0]      gnt;
    logic [2:0]      done;
    logic            err;
    logic [DW-1:0]   rdata;

    // master: the requester pool driving requests
    modport master (
        output req,
        output req_op,
        output req_wdata,
        input  gnt,
        input  done,
        input  err,
        input  rdata
    );

    // slave: the arbiter answering them
    modport slave (
        input  req,
        input  req_op,
        input  req_wdata,
        output gnt,
        output done,
        output err,
        output rdata
    );
endinterface

// File: rtl/dp_arbiter.sv
// Three-way round-robin arbiter in front of a dynamic pointer register.
// One transaction at a time: IDLE -> ISSUE -> (CAPTURE) -> RESP -> IDLE.
module dp_arbiter #(
    parameter int DW = 20
) (
    input  logic          clk,
    input  logic          reset,
    dp_arbiter_if.slave   bus,
    output logic          busy,
    output logic          dp_readsig,
    output logic          dp_writesig,
    output logic          dp_inc,
    output logic [DW-1:0] dp_data_in,
    input  logic [DW-1:0] dp_data_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_INC   = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    state_t        state_reg;
    op_t           op_reg;
    logic [1:0]    winner_reg;
    logic [2:0]    gnt_reg;
    logic [2:0]    done_reg;
    logic          err_reg;
    logic          rd_reg;
    logic          wr_reg;
    logic          inc_reg;
    logic [DW-1:0] rdata_reg;
    logic [DW-1:0] wdata_reg;

    // Requester index reached by stepping 'step' places past 'base', modulo 3.
    function automatic logic [1:0] rr_step(input logic [1:0] base, input logic [1:0] step);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, step};
        if (sum >= 3'd3) begin
            sum = sum - 3'd3;
        end
        return sum[1:0];
    endfunction

    logic [1:0]    op_of    [3];
    logic [DW-1:0] wdata_of [3];
    logic [1:0]    cand_idx [3];
    logic [2:0]    cand_hit;

    // Candidate gi is the requester gi+1 places after the last winner.
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        localparam logic [1:0] STEP = 2'(gi + 1);
        assign op_of[gi]    = bus.req_op[2*gi +: 2];
        assign wdata_of[gi] = bus.req_wdata[DW*gi +: DW];
        assign cand_idx[gi] = rr_step(winner_reg, STEP);
        assign cand_hit[gi] = bus.req[cand_idx[gi]];
    end

    logic       win_valid;
    logic [1:0] win_idx;
    op_t        win_op;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            if (cand_hit[k]) begin
                win_valid = 1'b1;
                win_idx   = cand_idx[k];
            end
        end
        win_op = op_t'(op_of[win_idx]);
    end

    // Strobes are registered on entry to ISSUE so they are high exactly while
    // in ISSUE; done/err are registered on leaving RESP, landing in the IDLE
    // cycle that can already accept the next request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            op_reg     <= OP_READ;
            winner_reg <= 2'd2;
            gnt_reg    <= '0;
            done_reg   <= '0;
            err_reg    <= 1'b0;
            rd_reg     <= 1'b0;
            wr_reg     <= 1'b0;
            inc_reg    <= 1'b0;
            rdata_reg  <= '0;
            wdata_reg  <= '0;
        end else begin
            done_reg <= '0;
            err_reg  <= 1'b0;
            rd_reg   <= 1'b0;
            wr_reg   <= 1'b0;
            inc_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (win_valid) begin
                        gnt_reg    <= 3'b001 << win_idx;
                        winner_reg <= win_idx;
                        op_reg     <= win_op;
                        wdata_reg  <= wdata_of[win_idx];
                        rd_reg     <= (win_op == OP_READ);
                        wr_reg     <= (win_op == OP_WRITE);
                        inc_reg    <= (win_op == OP_INC);
                        state_reg  <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_reg <= (op_reg == OP_READ) ? CAPTURE : RESP;
                end
                CAPTURE: begin
                    rdata_reg <= dp_data_out;
                    state_reg <= RESP;
                end
                RESP: begin
                    done_reg  <= gnt_reg;
                    err_reg   <= (op_reg == OP_RSVD);
                    gnt_reg   <= '0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_reg;
    assign bus.done    = done_reg;
    assign bus.err     = err_reg;
    assign bus.rdata   = rdata_reg;
    assign busy        = (state_reg != IDLE);
    assign dp_readsig  = rd_reg;
    assign dp_writesig = wr_reg;
    assign dp_inc      = inc_reg;
    assign dp_data_in  = wdata_reg;

endmodule

// File: tb/tb_dp_arbiter.sv
// Directed bench for dp_arbiter with a behavioural dynamic pointer attached.
module tb_dp_arbiter;
    localparam int DW = 20;

    logic          clk;
    logic          reset;
    logic          busy;
    logic          dp_readsig;
    logic          dp_writesig;
    logic          dp_inc;
    logic [DW-1:0] dp_data_in;
    logic [DW-1:0] dp_data_out;

    dp_arbiter_if #(.DW(DW)) bus ();

    dp_arbiter #(.DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .dp_readsig (dp_readsig),
        .dp_writesig(dp_writesig),
        .dp_inc     (dp_inc),
        .dp_data_in (dp_data_in),
        .dp_data_out(dp_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pointer register with registered read data; unaffected by arbiter reset.
    logic [DW-1:0] ptr_q  = '0;
    logic [DW-1:0] dout_q = '0;
    always @(posedge clk) begin
        if (dp_writesig) ptr_q <= dp_data_in;
        else if (dp_inc) ptr_q <= ptr_q + 1'b1;
        if (dp_readsig) dout_q <= ptr_q;
    end
    assign dp_data_out = dout_q;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] r, input logic [5:0] op, input logic [3*DW-1:0] wd);
        bus.req       = r;
        bus.req_op    = op;
        bus.req_wdata = wd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [2:0] rot_exp [4];

    initial begin
        rot_exp[0] = 3'b001; rot_exp[1] = 3'b010; rot_exp[2] = 3'b100; rot_exp[3] = 3'b001;
        reset = 1'b0;
        drive(3'b000, 6'b0, '0);
        @(negedge clk);
        check("rst_gnt",   bus.gnt, 3'b000);
        check("rst_done",  bus.done, 3'b000);
        check("rst_err",   bus.err, 1'b0);
        check("rst_busy",  busy, 1'b0);
        check("rst_rdata", bus.rdata, '0);
        check("rst_din",   dp_data_in, '0);
        check("rst_strb",  {dp_readsig, dp_writesig, dp_inc}, 3'b000);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Write 0x00ABC from requester 0
        drive(3'b001, 6'b000001, {40'h0, 20'h00ABC});
        @(negedge clk);
        check("wr_gnt",  bus.gnt, 3'b001);
        check("wr_strb", {dp_readsig, dp_writesig, dp_inc}, 3'b010);
        check("wr_din",  dp_data_in, 20'h00ABC);
        check("wr_busy", busy, 1'b1);
        drive(3'b000, 6'b0, '0);
        @(negedge clk);
        check("wr_strb_off", {dp_readsig, dp_writesig, dp_inc}, 3'b000);
        check("wr_done_early", bus.done, 3'b000);
        check("wr_gnt_hold", bus.gnt, 3'b001);
        @(negedge clk);
        check("wr_done", bus.done, 3'b001);
        check("wr_err",  bus.err, 1'b0);
        check("wr_gnt_clr", bus.gnt, 3'b000);
        check("wr_ptr",  ptr_q, 20'h00ABC);
        check("wr_din_hold", dp_data_in, 20'h00ABC);

        // Requester 1 writes 0x00010 so the pointer holds it
        drive(3'b010, 6'b000100, {20'h0, 20'h00010, 20'h0});
        @(negedge clk);
        check("wr1_gnt", bus.gnt, 3'b010);
        drive(3'b000, 6'b0, '0);
        @(negedge clk);
        @(negedge clk);
        check("wr1_done", bus.done, 3'b010);
        check("wr1_ptr", ptr_q, 20'h00010);

        // Read by requester 1: done three cycles after grant
        drive(3'b010, 6'b000000, '0);
        @(negedge clk);
        check("rd_gnt",  bus.gnt, 3'b010);
        check("rd_strb", {dp_readsig, dp_writesig, dp_inc}, 3'b100);
        drive(3'b000, 6'b0, '0);
        @(negedge clk);
        check("rd_strb_off", {dp_readsig, dp_writesig, dp_inc}, 3'b000);
        check("rd_busy_cap", busy, 1'b1);
        @(negedge clk);
        check("rd_done_early", bus.done, 3'b000);
        @(negedge clk);
        check("rd_done",  bus.done, 3'b010);
        check("rd_err",   bus.err, 1'b0);
        check("rd_rdata", bus.rdata, 20'h00010);

        // Reserved op from requester 2
        drive(3'b100, 6'b110000, {20'hFFFFF, 40'h0});
        @(negedge clk);
        check("rsv_gnt",  bus.gnt, 3'b100);
        check("rsv_strb", {dp_readsig, dp_writesig, dp_inc}, 3'b000);
        drive(3'b000, 6'b0, '0);
        @(negedge clk);
        check("rsv_done_early", bus.done, 3'b000);
        @(negedge clk);
        check("rsv_done",  bus.done, 3'b100);
        check("rsv_err",   bus.err, 1'b1);
        check("rsv_rdata", bus.rdata, 20'h00010);
        check("rsv_ptr",   ptr_q, 20'h00010);

        // Three continuous inc requesters: strict rotation, 3 cycles each
        drive(3'b111, 6'b101010, '0);
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            check($sformatf("rot%0d_gnt", t), bus.gnt, rot_exp[t]);
            check($sformatf("rot%0d_inc", t), dp_inc, 1'b1);
            @(negedge clk);
            @(negedge clk);
            check($sformatf("rot%0d_done", t), bus.done, rot_exp[t]);
            if (t == 3) drive(3'b000, 6'b0, '0);
        end
        check("rot_ptr", ptr_q, 20'h00014);
        check("rot_rdata", bus.rdata, 20'h00010);

        // Winner drops req right after the grant
        drive(3'b001, 6'b000010, '0);
        @(negedge clk);
        check("drop_gnt", bus.gnt, 3'b001);
        check("drop_inc", dp_inc, 1'b1);
        drive(3'b000, 6'b0, '0);
        @(negedge clk);
        check("drop_inc_off", dp_inc, 1'b0);
        @(negedge clk);
        check("drop_done", bus.done, 3'b001);
        check("drop_ptr",  ptr_q, 20'h00015);

        // Reset during CAPTURE of a read
        drive(3'b010, 6'b000000, '0);
        @(negedge clk);
        check("ab_rd_strb", dp_readsig, 1'b1);
        drive(3'b000, 6'b0, '0);
        @(negedge clk);
        check("ab_busy", busy, 1'b1);
        #1 reset = 1'b0;
        #1;
        check("ab_gnt",   bus.gnt, 3'b000);
        check("ab_busy0", busy, 1'b0);
        check("ab_rdata", bus.rdata, '0);
        check("ab_din",   dp_data_in, '0);
        check("ab_strb",  {dp_readsig, dp_writesig, dp_inc}, 3'b000);
        @(negedge clk);
        check("ab_done", bus.done, 3'b000);
        reset = 1'b1;
        drive(3'b111, 6'b101010, '0);
        @(negedge clk);
        check("post_rst_gnt", bus.gnt, 3'b001);
        drive(3'b000, 6'b0, '0);
        @(negedge clk);
        @(negedge clk);
        check("post_rst_done", bus.done, 3'b001);
        check("post_rst_ptr", ptr_q, 20'h00016);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
